// File: rtl/fsm_main_control.sv
`default_nettype none
// ============================================================================
// Module   : fsm_main_control
// Brief    : Turns each rising press of exe into one single-cycle, one-hot
//            USR control pulse selected by slide.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_main_control (
    input  logic       clk,
    input  logic       reset,
    input  logic       exe,
    input  logic [1:0] slide,
    output logic [3:0] Q_out
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [1:0] r_op;
    logic       w_capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_op    <= 2'b00;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_op <= slide;
            end
        end
    end

    // The unused code 2'd3 falls into the default arm and returns to IDLE.
    always_comb begin
        w_state_next = c_ST_IDLE;
        w_capture    = 1'b0;
        Q_out        = 4'b0000;
        case (r_state)
            c_ST_IDLE: begin
                if (exe) begin
                    w_state_next = c_ST_EXEC;
                    w_capture    = 1'b1;
                end
            end
            c_ST_EXEC: begin
                w_state_next = exe ? c_ST_WAIT : c_ST_IDLE;
                case (r_op)
                    2'b00:   Q_out = 4'b0001;
                    2'b01:   Q_out = 4'b0010;
                    2'b10:   Q_out = 4'b0100;
                    default: Q_out = 4'b1000;
                endcase
            end
            c_ST_WAIT: begin
                w_state_next = exe ? c_ST_WAIT : c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_main_control
// Brief    : Self-checking bench for fsm_main_control: directed presses with
//            literal expectations plus a randomized run against a press model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_main_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       exe = 1'b0;
    logic [1:0] slide = 2'b00;
    logic [3:0] Q_out;

    int unsigned r_vectors = 0;
    int unsigned r_miscompares = 0;

    // Model state: a press is honoured only when exe has been seen low since
    // the previous operation (or since reset).
    logic       r_model_valid = 1'b0;
    logic       r_armed = 1'b1;
    logic [3:0] r_expected = 4'b0000;

    fsm_main_control u_dut (
        .clk   (clk),
        .reset (reset),
        .exe   (exe),
        .slide (slide),
        .Q_out (Q_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            r_model_valid = 1'b1;
            r_armed       = 1'b1;
            r_expected    = 4'b0000;
        end else if (exe && r_armed) begin
            r_expected = 4'b0001 << slide;
            r_armed    = 1'b0;
        end else begin
            r_expected = 4'b0000;
            if (!exe) begin
                r_armed = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (r_model_valid) begin
            r_vectors++;
            if (Q_out !== r_expected) begin
                r_miscompares++;
                $display("FAIL cycle_model t=%0t Q_out=%b expected=%b", $time, Q_out, r_expected);
            end
        end
    end

    task automatic apply(input logic r, input logic e, input logic [1:0] s);
        reset = r;
        exe   = e;
        slide = s;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input logic [3:0] exp_val, input string name);
        r_vectors++;
        if (Q_out !== exp_val) begin
            r_miscompares++;
            $display("FAIL %s Q_out=%b expected=%b", name, Q_out, exp_val);
        end
    endtask

    initial begin
        // Reset with slide=01 and exe low.
        apply(1'b1, 1'b0, 2'b01);
        lit(4'b0000, "reset");
        apply(1'b0, 1'b0, 2'b01);
        lit(4'b0000, "idle_after_reset");

        // Single one-cycle press.
        apply(1'b0, 1'b1, 2'b01);
        lit(4'b0010, "single_pulse");
        apply(1'b0, 1'b0, 2'b01);
        lit(4'b0000, "single_end");

        // Three presses separated by one low cycle.
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 2'b01);
            lit(4'b0010, "repeat_pulse");
            apply(1'b0, 1'b0, 2'b01);
            lit(4'b0000, "repeat_gap");
        end

        // Held exe: one pulse, then silence until release and re-press.
        apply(1'b0, 1'b1, 2'b10);
        lit(4'b0100, "held_pulse");
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 2'b10);
            lit(4'b0000, "held_quiet");
        end
        apply(1'b0, 1'b0, 2'b10);
        lit(4'b0000, "held_release");
        apply(1'b0, 1'b1, 2'b10);
        lit(4'b0100, "held_repress");
        apply(1'b0, 1'b0, 2'b10);

        // Decode sweep; slide changes while in EXEC must not disturb the pulse.
        for (int s = 0; s < 4; s++) begin
            logic [1:0] sel;
            logic [3:0] onehot;
            sel    = 2'(s);
            onehot = 4'b0001 << sel;
            apply(1'b0, 1'b1, sel);
            lit(onehot, "decode");
            slide = ~sel;
            #1;
            lit(onehot, "decode_slide_change");
            apply(1'b0, 1'b0, ~sel);
            lit(4'b0000, "decode_end");
        end

        // Reset during EXEC, then during WAIT, with exe held high throughout.
        apply(1'b0, 1'b1, 2'b11);
        lit(4'b1000, "midop_exec");
        apply(1'b1, 1'b1, 2'b11);
        lit(4'b0000, "reset_in_exec");
        apply(1'b0, 1'b1, 2'b11);
        lit(4'b1000, "fresh_after_exec_reset");
        apply(1'b0, 1'b1, 2'b11);
        lit(4'b0000, "midop_wait");
        apply(1'b1, 1'b1, 2'b11);
        lit(4'b0000, "reset_in_wait");
        apply(1'b0, 1'b1, 2'b11);
        lit(4'b1000, "fresh_after_wait_reset");
        apply(1'b0, 1'b0, 2'b11);
        lit(4'b0000, "midop_end");

        // Randomized run, checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic e;
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 99) < 55);
            apply(r, e, 2'($urandom_range(0, 3)));
        end
        apply(1'b0, 1'b0, 2'b00);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", r_vectors, r_miscompares);
        $finish;
    end

endmodule
`default_nettype wire
